// File: rtl/pong_link_tx_scheduler_if.sv
// UART TX FIFO write port shared by the link scheduler and the FIFO.
//   w_data  : byte presented to the FIFO
//   wr_uart : one-cycle write strobe
//   tx_full : FIFO full, writes are held off while high
interface pong_link_tx_scheduler_if;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       tx_full;

  modport master (output w_data, output wr_uart, input tx_full);
  modport slave  (input w_data, input wr_uart, output tx_full);
endinterface

// File: rtl/pong_link_tx_scheduler.sv
// Board-to-board link transmit scheduler. Turns pad, ball and score updates
// into fixed-format packets and feeds them byte by byte into the UART TX FIFO.
//   clk, rst            : clock, synchronous active-low reset
//   timing_tick         : frame tick, raises PAD (and BALL when master)
//   master              : this board owns ball/score traffic
//   y_pad, x_ball, y_ball, score_left, score_right : packet payloads
//   score_event         : score changed, raises SCORE when master
//   uart                : FIFO write port (w_data, wr_uart, tx_full)
//   busy                : packet or inter-packet gap in progress
//   drop_cnt            : saturating count of merged requests
module pong_link_tx_scheduler #(
  parameter logic [7:0]  PAD_HDR    = 8'hA1,
  parameter logic [7:0]  BALL_HDR   = 8'hB2,
  parameter logic [7:0]  SCORE_HDR  = 8'hC3,
  parameter int unsigned GAP_CYCLES = 32'd2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             timing_tick,
  input  logic                             master,
  input  logic [9:0]                       y_pad,
  input  logic [9:0]                       x_ball,
  input  logic [9:0]                       y_ball,
  input  logic [3:0]                       score_left,
  input  logic [3:0]                       score_right,
  input  logic                             score_event,
  pong_link_tx_scheduler_if.master         uart,
  output logic                             busy,
  output logic [7:0]                       drop_cnt
);

  localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 32'd0) ? 16'd0 : 16'(GAP_CYCLES - 32'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t      state_r;
  logic        pad_p_r, ball_p_r, score_p_r;
  logic [39:0] pkt_r;      // snapshot, byte 0 in [39:32]
  logic [2:0]  len_r;
  logic [2:0]  idx_r;
  logic [15:0] gap_cnt_r;
  logic [7:0]  hold_r;     // last byte written, shown while idle
  logic        busy_r;
  logic [7:0]  drop_r;

  logic        req_pad_s, req_ball_s, req_score_s;
  logic        win_pad_s, win_ball_s, win_score_s, start_s;
  logic [39:0] pkt_next_s;
  logic [2:0]  len_next_s;
  logic [7:0]  cur_byte_s;
  logic        wr_s, last_s;
  logic [1:0]  n_drop_s;
  logic [8:0]  drop_sum_s;
  logic [7:0]  drop_next_s;

  assign req_pad_s   = timing_tick;
  assign req_ball_s  = timing_tick & master;
  assign req_score_s = score_event & master;

  // Fixed-priority arbitration among pending flags, only while idle.
  always_comb begin
    win_score_s = 1'b0;
    win_ball_s  = 1'b0;
    win_pad_s   = 1'b0;
    if (state_r == IDLE) begin
      if (score_p_r) begin
        win_score_s = 1'b1;
      end else if (ball_p_r) begin
        win_ball_s = 1'b1;
      end else begin
        win_pad_s = pad_p_r;
      end
    end else begin
      win_score_s = 1'b0;
    end
  end

  assign start_s = win_score_s | win_ball_s | win_pad_s;

  // Build the snapshot of the winning packet from the live inputs.
  always_comb begin
    pkt_next_s = 40'h0;
    len_next_s = 3'd3;
    if (win_score_s) begin
      pkt_next_s = {SCORE_HDR, 4'h0, score_left, 4'h0, score_right, 16'h0000};
      len_next_s = 3'd3;
    end else if (win_ball_s) begin
      pkt_next_s = {BALL_HDR, 6'd0, x_ball[9:8], x_ball[7:0], 6'd0, y_ball[9:8], y_ball[7:0]};
      len_next_s = 3'd5;
    end else begin
      pkt_next_s = {PAD_HDR, 6'd0, y_pad[9:8], y_pad[7:0], 16'h0000};
      len_next_s = 3'd3;
    end
  end

  // Current byte of the snapshot selected by the byte index.
  always_comb begin
    cur_byte_s = 8'h00;
    case (idx_r)
      3'd0:    cur_byte_s = pkt_r[39:32];
      3'd1:    cur_byte_s = pkt_r[31:24];
      3'd2:    cur_byte_s = pkt_r[23:16];
      3'd3:    cur_byte_s = pkt_r[15:8];
      3'd4:    cur_byte_s = pkt_r[7:0];
      default: cur_byte_s = 8'h00;
    endcase
  end

  // Merge counting: a request hitting a still-set flag is lost; a request on
  // the cycle its flag is being consumed becomes the next pending request.
  always_comb begin
    n_drop_s    = {1'b0, req_pad_s & pad_p_r & ~win_pad_s}
                + {1'b0, req_ball_s & ball_p_r & ~win_ball_s}
                + {1'b0, req_score_s & score_p_r & ~win_score_s};
    drop_sum_s  = {1'b0, drop_r} + {7'd0, n_drop_s};
    drop_next_s = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
  end

  // The write strobe follows the live tx_full so a full FIFO is never written.
  assign wr_s         = (state_r == SEND) & ~uart.tx_full;
  assign last_s       = (idx_r == (len_r - 3'd1));
  assign uart.wr_uart = wr_s;
  assign uart.w_data  = wr_s ? cur_byte_s : hold_r;
  assign busy         = busy_r;
  assign drop_cnt     = drop_r;

  // Pending flags, drop counter and IDLE/SEND/GAP sequencing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      pad_p_r   <= 1'b0;
      ball_p_r  <= 1'b0;
      score_p_r <= 1'b0;
      pkt_r     <= 40'h0;
      len_r     <= 3'd0;
      idx_r     <= 3'd0;
      gap_cnt_r <= 16'd0;
      hold_r    <= 8'h00;
      busy_r    <= 1'b0;
      drop_r    <= 8'h00;
    end else begin
      pad_p_r   <= (pad_p_r & ~win_pad_s) | req_pad_s;
      ball_p_r  <= (ball_p_r & ~win_ball_s) | req_ball_s;
      score_p_r <= (score_p_r & ~win_score_s) | req_score_s;
      drop_r    <= drop_next_s;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r <= SEND;
            busy_r  <= 1'b1;
            idx_r   <= 3'd0;
            pkt_r   <= pkt_next_s;
            len_r   <= len_next_s;
          end else begin
            busy_r <= 1'b0;
          end
        end
        SEND: begin
          if (wr_s) begin
            hold_r <= cur_byte_s;
            if (last_s) begin
              idx_r <= 3'd0;
              if (GAP_CYCLES > 32'd0) begin
                state_r   <= GAP;
                gap_cnt_r <= 16'd0;
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_link_tx_scheduler.sv
module tb_pong_link_tx_scheduler;
  localparam int GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, timing_tick = 1'b0, master = 1'b0, score_event = 1'b0, tx_full = 1'b0;
  logic [9:0] y_pad = 10'd0, x_ball = 10'd0, y_ball = 10'd0;
  logic [3:0] score_left = 4'd0, score_right = 4'd0;
  logic       busy, z_busy;
  logic [7:0] drop_cnt, z_drop;

  pong_link_tx_scheduler_if u_if();
  pong_link_tx_scheduler_if z_if();
  assign u_if.tx_full = tx_full;
  assign z_if.tx_full = tx_full;

  pong_link_tx_scheduler #(.GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .master(master),
    .y_pad(y_pad), .x_ball(x_ball), .y_ball(y_ball),
    .score_left(score_left), .score_right(score_right), .score_event(score_event),
    .uart(u_if), .busy(busy), .drop_cnt(drop_cnt));

  pong_link_tx_scheduler #(.GAP_CYCLES(0)) z_dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .master(master),
    .y_pad(y_pad), .x_ball(x_ball), .y_ball(y_ball),
    .score_left(score_left), .score_right(score_right), .score_event(score_event),
    .uart(z_if), .busy(z_busy), .drop_cnt(z_drop));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (packet/flag level) ----------------
  bit         f_p = 1'b0, f_b = 1'b0, f_s = 1'b0;   // pending requests
  int         m_rem = 0;     // bytes of current packet still to write
  int         m_gap = 0;     // gap cycles still to spend
  int         m_drop = 0;
  bit         rst_q = 1'b0;
  int         cyc = 0;
  logic [7:0] exp_q[$];      // scoreboard of expected bytes

  function automatic int pick(bit idle, bit s, bit b, bit p);
    if (!idle) return 0;
    if (s) return 3;
    if (b) return 2;
    if (p) return 1;
    return 0;
  endfunction

  function automatic int sat255(int v);
    return (v > 255) ? 255 : v;
  endfunction

  int win_w;
  bit rp_w, rb_w, rs_w;
  assign win_w = pick(m_rem == 0 && m_gap == 0, f_s, f_b, f_p);
  assign rp_w  = timing_tick;
  assign rb_w  = timing_tick && master;
  assign rs_w  = score_event && master;

  task automatic push_pkt(input int kind);
    if (kind == 3) begin
      exp_q.push_back(8'hC3);
      exp_q.push_back({4'h0, score_left});
      exp_q.push_back({4'h0, score_right});
    end else if (kind == 2) begin
      exp_q.push_back(8'hB2);
      exp_q.push_back(8'(x_ball / 256));
      exp_q.push_back(8'(x_ball % 256));
      exp_q.push_back(8'(y_ball / 256));
      exp_q.push_back(8'(y_ball % 256));
    end else begin
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'(y_pad / 256));
      exp_q.push_back(8'(y_pad % 256));
    end
  endtask

  // Model advances on each clock edge from the inputs of the ending cycle.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    if (!rst) begin
      f_p <= 1'b0; f_b <= 1'b0; f_s <= 1'b0;
      m_rem <= 0; m_gap <= 0; m_drop <= 0;
      exp_q.delete();
    end else begin
      if (win_w != 0) begin
        push_pkt(win_w);
        m_rem <= (win_w == 2) ? 5 : 3;
      end else if (m_rem > 0) begin
        if (!tx_full) begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_gap <= GAP;
        end
      end else if (m_gap > 0) begin
        m_gap <= m_gap - 1;
      end
      m_drop <= sat255(m_drop + int'(rp_w && f_p && win_w != 1)
                              + int'(rb_w && f_b && win_w != 2)
                              + int'(rs_w && f_s && win_w != 3));
      f_p <= (f_p && win_w != 1) || rp_w;
      f_b <= (f_b && win_w != 2) || rb_w;
      f_s <= (f_s && win_w != 3) || rs_w;
    end
  end

  // ---------------- monitors ----------------
  bit         mon_en = 1'b0;
  logic [7:0] m_last = 8'h00;
  logic [7:0] log_q[$];
  int         log_cyc[$];
  logic [7:0] z_bytes[$];
  int         z_cyc[$];

  always @(negedge clk) begin
    if (mon_en) begin
      chk("wr_uart", int'(u_if.wr_uart), int'(m_rem > 0 && !tx_full));
      if (u_if.wr_uart) begin
        log_q.push_back(u_if.w_data);
        log_cyc.push_back(cyc);
        chk("exp_avail", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("w_data", int'(u_if.w_data), int'(exp_q[0]));
          m_last <= exp_q[0];
          void'(exp_q.pop_front());
        end
      end else if (!rst_q) begin
        chk("w_data_rst", int'(u_if.w_data), 0);
        m_last <= 8'h00;
      end else begin
        chk("w_data_hold", int'(u_if.w_data), int'(m_last));
      end
      chk("busy", int'(busy), int'(m_rem > 0 || m_gap > 0));
      chk("drop_cnt", int'(drop_cnt), m_drop);
    end
  end

  always @(negedge clk) begin
    if (mon_en && z_if.wr_uart) begin
      z_bytes.push_back(z_if.w_data);
      z_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    timing_tick = 1'b0; score_event = 1'b0; tx_full = 1'b0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(m_rem == 0 && m_gap == 0 && !f_p && !f_b && !f_s) && n < 400) begin
      step(1);
      n++;
    end
    chk({name, "_timeout"}, int'(n < 400), 1);
    step(2);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic wait_log(input int target, input string name);
    int n = 0;
    while (log_q.size() < target && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    chk({name, "_wait"}, int'(log_q.size() >= target), 1);
  endtask

  logic [7:0] t2_exp[11] = '{8'hC3, 8'h03, 8'h07, 8'hB2, 8'h02, 8'h80, 8'h00, 8'h05, 8'hA1, 8'h01, 8'h38};
  logic [7:0] t1_exp[3]  = '{8'hA1, 8'h01, 8'h38};

  initial begin
    int base, t0, zb;
    step(3);
    rst = 1'b1;
    mon_en = 1'b1;
    step(1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_wr", int'(u_if.wr_uart), 0);
    chk("rst_wdata", int'(u_if.w_data), 0);

    // 1: single PAD packet, latency and gap
    master = 1'b0; y_pad = 10'd312;
    base = log_q.size(); t0 = cyc;
    timing_tick = 1'b1; step(1); timing_tick = 1'b0;
    wait_idle("t1");
    chk("t1_count", log_q.size() - base, 3);
    for (int i = 0; i < 3 && base + i < log_q.size(); i++) chk("t1_byte", int'(log_q[base + i]), int'(t1_exp[i]));
    if (log_q.size() > base) chk("t1_latency", log_cyc[base] - t0, 2);
    chk("t1_drop", int'(drop_cnt), 0);

    // 2: SCORE > BALL > PAD ordering
    master = 1'b1; x_ball = 10'd640; y_ball = 10'd5; score_left = 4'd3; score_right = 4'd7;
    base = log_q.size();
    timing_tick = 1'b1; score_event = 1'b1; step(1); timing_tick = 1'b0; score_event = 1'b0;
    wait_idle("t2");
    chk("t2_count", log_q.size() - base, 11);
    for (int i = 0; i < 11 && base + i < log_q.size(); i++) chk("t2_byte", int'(log_q[base + i]), int'(t2_exp[i]));

    // 3: stall with tx_full after the header, payload snapshot held
    master = 1'b0; y_pad = 10'd312;
    base = log_q.size();
    timing_tick = 1'b1; step(1); timing_tick = 1'b0;
    wait_log(base + 1, "t3_hdr");
    @(posedge clk); #1;
    tx_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i == 4) begin
        y_pad = 10'd100;
        chk("t3_stall_wdata", int'(u_if.w_data), 8'hA1);
        chk("t3_stall_wr", int'(u_if.wr_uart), 0);
      end
    end
    tx_full = 1'b0;
    wait_idle("t3");
    chk("t3_count", log_q.size() - base, 3);
    for (int i = 0; i < 3 && base + i < log_q.size(); i++) chk("t3_byte", int'(log_q[base + i]), int'(t1_exp[i]));

    // 4: merged ticks and saturation
    do_reset();
    master = 1'b0; y_pad = 10'd312;
    base = log_q.size();
    timing_tick = 1'b1; step(1); timing_tick = 1'b0; step(1);
    timing_tick = 1'b1; step(3); timing_tick = 1'b0;
    wait_idle("t4");
    chk("t4_count", log_q.size() - base, 6);
    chk("t4_drop", int'(drop_cnt), 2);
    timing_tick = 1'b1; step(400); timing_tick = 1'b0;
    wait_idle("t4s");
    chk("t4_sat", int'(drop_cnt), 255);

    // 5: reset in the middle of a BALL packet
    do_reset();
    master = 1'b1; x_ball = 10'd640; y_ball = 10'd5;
    base = log_q.size();
    timing_tick = 1'b1; step(1); timing_tick = 1'b0;
    wait_log(base + 2, "t5_two");
    rst = 1'b0;
    step(3);
    chk("t5_busy", int'(busy), 0);
    chk("t5_wr", int'(u_if.wr_uart), 0);
    chk("t5_wdata", int'(u_if.w_data), 0);
    chk("t5_drop", int'(drop_cnt), 0);
    rst = 1'b1;
    step(20);
    chk("t5_count", log_q.size() - base, 2);
    if (log_q.size() >= base + 2) begin
      chk("t5_b0", int'(log_q[base]), 8'hB2);
      chk("t5_b1", int'(log_q[base + 1]), 8'h02);
    end

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      timing_tick = ($urandom_range(7) == 0);
      score_event = ($urandom_range(9) == 0);
      master      = ($urandom_range(5) != 0);
      tx_full     = ($urandom_range(3) == 0);
      y_pad = 10'($urandom_range(1023)); x_ball = 10'($urandom_range(1023)); y_ball = 10'($urandom_range(1023));
      score_left = 4'($urandom_range(15)); score_right = 4'($urandom_range(15));
      step(1);
    end
    timing_tick = 1'b0; score_event = 1'b0; tx_full = 1'b0;
    wait_idle("rand");

    // 6: slave ignores score events; zero-gap build runs back-to-back
    do_reset();
    master = 1'b0; y_pad = 10'd312;
    base = log_q.size();
    for (int i = 0; i < 4; i++) begin
      score_event = 1'b1; step(1); score_event = 1'b0; step(2);
    end
    step(5);
    chk("t6_none", log_q.size() - base, 0);
    chk("t6_drop", int'(drop_cnt), 0);
    master = 1'b1; x_ball = 10'd640; y_ball = 10'd5; score_left = 4'd3; score_right = 4'd7;
    zb = z_bytes.size();
    timing_tick = 1'b1; score_event = 1'b1; step(1); timing_tick = 1'b0; score_event = 1'b0;
    wait_idle("t6");
    chk("t6_zcount", z_bytes.size() - zb, 11);
    if (z_bytes.size() - zb == 11) begin
      for (int i = 0; i < 11; i++) chk("t6_zbyte", int'(z_bytes[zb + i]), int'(t2_exp[i]));
      for (int i = 1; i < 11; i++) chk("t6_zspacing", z_cyc[zb + i] - z_cyc[zb + i - 1], (i == 3 || i == 8) ? 2 : 1);
    end
    chk("t6_zbusy", int'(z_busy), 0);
    chk("t6_zdrop", int'(z_drop), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
